dm_bus_initiator: RTL

//  CPU-side initiator for data-memory accesses over a req/ack bus with variable latency.
//  - Sits in the M stage and takes one load/store per instruction.
//  - Produces a word-aligned address, byte enables and lane-replicated write data.
//  - Stalls the pipeline until the slave acks, then returns sign/zero-extended load data.
//  - Flags misaligned accesses and bus timeouts instead of issuing them.

---
 rtl/dm_bus_initiator_pkg.sv | 40 ++++
 rtl/dm_lane_fmt.sv | 65 ++++++
 rtl/dm_bus_initiator.sv | 134 +++++++++++++
 3 files changed

// File: rtl/dm_bus_initiator_pkg.sv
// Shared constants for the data-memory bus initiator: access-type codes,
// FSM state encoding, the latched-request record and the alignment rule.
package dm_bus_initiator_pkg;

  // Access-type codes, identical to the ones the data memory decodes.
  localparam logic [2:0] DMTYPE_WORD  = 3'd0;
  localparam logic [2:0] DMTYPE_HALF  = 3'd1;
  localparam logic [2:0] DMTYPE_BYTE  = 3'd2;
  localparam logic [2:0] DMTYPE_HALFU = 3'd3;
  localparam logic [2:0] DMTYPE_BYTEU = 3'd4;
  localparam logic [2:0] DMTYPE_SWL   = 3'd5;
  localparam logic [2:0] DMTYPE_SWR   = 3'd6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_e;

  // Request captured on accept; everything driven onto the bus comes from here.
  typedef struct packed {
    logic        we;
    logic [2:0]  dtype;
    logic [31:0] addr;
    logic [31:0] wdata;
  } dm_req_t;

  // Word accesses (and unknown codes) need A=0, halves need an even address;
  // byte-granular and swl/swr accesses can start on any byte.
  function automatic logic dm_misaligned(input logic [2:0] dtype, input logic [1:0] a);
    logic mis;
    case (dtype)
      DMTYPE_HALF, DMTYPE_HALFU:                          mis = a[0];
      DMTYPE_BYTE, DMTYPE_BYTEU, DMTYPE_SWL, DMTYPE_SWR:  mis = 1'b0;
      default:                                            mis = (a != 2'b00);
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/dm_lane_fmt.sv
// Combinational lane formatter: byte enables and lane-placed write data for
// stores, and extraction plus sign/zero extension for loads.
module dm_lane_fmt
  import dm_bus_initiator_pkg::*;
(
  input  logic        we,
  input  logic [2:0]  dtype,
  input  logic [1:0]  a,
  input  logic [31:0] wd,
  input  logic [31:0] w,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] rdata
);

  logic [15:0] half_w;
  logic [7:0]  byte_w;

  assign half_w = w[{a[1], 4'b0000} +: 16];
  assign byte_w = w[{a, 3'b000} +: 8];

  // Store side: which lanes are written and what each lane carries.
  always_comb begin
    // NOTE: every output gets a default before the case so no path can infer a latch.
    be    = 4'b1111;
    wdata = '0;
    if (we) begin
      case (dtype)
        DMTYPE_HALF, DMTYPE_HALFU: begin
          be    = a[1] ? 4'b1100 : 4'b0011;
          wdata = {2{wd[15:0]}};
        end
        DMTYPE_BYTE, DMTYPE_BYTEU: begin
          be    = 4'b0001 << a;
          wdata = {4{wd[7:0]}};
        end
        DMTYPE_SWL: begin
          be    = 4'b1111 >> ~a;
          wdata = wd >> {~a, 3'b000};
        end
        DMTYPE_SWR: begin
          be    = 4'b1111 << a;
          wdata = wd << {a, 3'b000};
        end
        default: begin
          be    = 4'b1111;
          wdata = wd;
        end
      endcase
    end
  end

  // Load side: pick the addressed half/byte and extend it; anything else is the raw word.
  always_comb begin
    rdata = w;
    case (dtype)
      DMTYPE_HALF:  rdata = {{16{half_w[15]}}, half_w};
      DMTYPE_HALFU: rdata = {16'h0000, half_w};
      DMTYPE_BYTE:  rdata = {{24{byte_w[7]}}, byte_w};
      DMTYPE_BYTEU: rdata = {24'h000000, byte_w};
      default:      rdata = w;
    endcase
  end

endmodule

// File: rtl/dm_bus_initiator.sv
// M-stage data-memory initiator: accepts one load/store, drives a req/ack bus
// with a timeout, stalls the pipeline meanwhile and returns formatted load data.
module dm_bus_initiator
  import dm_bus_initiator_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [2:0]  req_type,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic [31:0] rdata,
  output logic        rdata_valid,
  output logic        align_err,
  output logic        bus_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_e           state_q, state_d;
  dm_req_t          req_q;
  logic [31:0]      word_q;
  logic             abort_q;
  logic [CNT_W-1:0] cnt_q;
  logic             accept;
  logic             timeout_hit;
  logic [3:0]       fmt_be;
  logic [31:0]      fmt_wdata;
  logic [31:0]      fmt_rdata;

  assign timeout_hit = (cnt_q == CNT_LAST);

  // State register; an async reset returns to IDLE, which drops bus_req at once.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: non-blocking assignments so every register sees pre-edge values.
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_d     = state_q;
    accept      = 1'b0;
    stall       = 1'b0;
    align_err   = 1'b0;
    bus_req     = 1'b0;
    rdata_valid = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (dm_misaligned(req_type, req_addr[1:0])) begin
            align_err = 1'b1;
          end else begin
            stall   = 1'b1;
            accept  = 1'b1;
            state_d = REQ;
          end
        end
      end
      REQ: begin
        bus_req = 1'b1;
        stall   = 1'b1;
        if (bus_ack || timeout_hit) state_d = RESP;
      end
      RESP: begin
        rdata_valid = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Capture the request on accept so the bus side never follows the pipeline.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: the request register is reset as well, so nothing stale survives a reset.
    if (reset)       req_q <= '0;
    else if (accept) req_q <= '{we: req_we, dtype: req_type, addr: req_addr, wdata: req_wdata};
  end

  // Response word, abort flag and timeout counter, all advanced only in REQ.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      word_q  <= '0;
      abort_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      if (accept) abort_q <= 1'b0;
      if (state_q == REQ) begin
        if (bus_ack) begin
          word_q <= bus_rdata;
          cnt_q  <= '0;
        end else if (timeout_hit) begin
          abort_q <= 1'b1;
          cnt_q   <= '0;
        end else begin
          cnt_q <= cnt_q + CNT_W'(1);
        end
      end
    end
  end

  dm_lane_fmt u_lane_fmt (
    .we    (req_q.we),
    .dtype (req_q.dtype),
    .a     (req_q.addr[1:0]),
    .wd    (req_q.wdata),
    .w     (word_q),
    .be    (fmt_be),
    .wdata (fmt_wdata),
    .rdata (fmt_rdata)
  );

  // Bus fields come only from latched state, held at zero outside REQ.
  assign bus_we    = bus_req & req_q.we;
  assign bus_addr  = bus_req ? {req_q.addr[31:2], 2'b00} : '0;
  assign bus_be    = bus_req ? fmt_be : '0;
  assign bus_wdata = bus_req ? fmt_wdata : '0;

  assign bus_err = rdata_valid & abort_q;
  assign rdata   = (rdata_valid && !abort_q && !req_q.we) ? fmt_rdata : '0;

endmodule
